// File: rtl/j2k_hdr_pkg.sv
// rtl/j2k_hdr_pkg.sv - shared encodings for the packet-header bit parser.
package j2k_hdr_pkg;

    localparam logic [1:0] MODE_FIELD = 2'b00;
    localparam logic [1:0] MODE_UNARY = 2'b01;
    localparam logic [1:0] MODE_ALIGN = 2'b10;

    localparam logic [7:0] STUFF_BYTE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        FIELD_W,
        UNARY_W,
        ALIGN,
        RESP
    } hdr_state_e;

endpackage

// File: rtl/axis_byte_serializer.sv
// rtl/axis_byte_serializer.sv - word-to-byte lane unpacker; lane 0 leaves first.
module axis_byte_serializer #(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W/8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [7:0]        m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    input  logic              m_axis_tready
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;

    assign s_axis_tready = ready_q;
    assign m_axis_tdata  = data_q[7:0];
    assign m_axis_tvalid = keep_q[0];
    assign m_axis_tlast  = last_q && ((keep_q >> 1) == '0);

    always_comb begin
        data_d = data_q;
        keep_d = keep_q;
        last_d = last_q;
        if (m_axis_tvalid && m_axis_tready) begin
            data_d = data_q >> 8;
            keep_d = keep_q >> 1;
        end
        // A zero-keep word is captured as an empty buffer, which drops it.
        if (s_axis_tvalid && ready_q) begin
            data_d = s_axis_tdata;
            keep_d = s_axis_tkeep;
            last_d = s_axis_tlast;
        end
        ready_d = (keep_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/bit_disassembler.sv
// rtl/bit_disassembler.sv - header bit parser with 0xFF bit-unstuffing.
// Optional HDR_STUFF_CHK_EN adds a sticky stuff_err_o for a set stuffed MSB.
module bit_disassembler
    import j2k_hdr_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int KEEP_W     = DATA_W/8,
    parameter int BIT_CNT_W  = 6,
    parameter int HDR_DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_axis_hdr_rx_valid_i,
    input  logic                  s_axis_hdr_rx_last_i,
    input  logic [DATA_W-1:0]     s_axis_hdr_rx_data_i,
    input  logic [KEEP_W-1:0]     s_axis_hdr_rx_keep_i,
    output logic                  s_axis_hdr_rx_ready_o,
    input  logic                  req_valid_i,
    input  logic [1:0]            req_mode_i,
    input  logic [BIT_CNT_W-1:0]  req_bit_cnt_i,
    output logic                  req_ready_o,
    output logic                  rsp_valid_o,
    output logic [HDR_DATA_W-1:0] rsp_data_o,
    output logic                  rsp_last_o,
`ifdef HDR_STUFF_CHK_EN
    output logic                  stuff_err_o,
`endif
    input  logic                  rsp_ready_i
);

    localparam int RES_W = HDR_DATA_W + 8;
    localparam int CNT_W = $clog2(RES_W + 1);
    localparam logic [CNT_W-1:0] HDR_W_C  = CNT_W'(HDR_DATA_W);
    localparam logic [CNT_W-1:0] LOAD_MAX = CNT_W'(RES_W - 8);
    localparam logic [RES_W-1:0] TOP_BIT  = {1'b1, {(RES_W-1){1'b0}}};

    logic [7:0] byte_tdata;
    logic       byte_tvalid, byte_tlast, byte_tready;

    axis_byte_serializer #(.DATA_W(DATA_W), .KEEP_W(KEEP_W)) u_ser (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_hdr_rx_data_i),
        .s_axis_tkeep  (s_axis_hdr_rx_keep_i),
        .s_axis_tvalid (s_axis_hdr_rx_valid_i),
        .s_axis_tlast  (s_axis_hdr_rx_last_i),
        .s_axis_tready (s_axis_hdr_rx_ready_o),
        .m_axis_tdata  (byte_tdata),
        .m_axis_tvalid (byte_tvalid),
        .m_axis_tlast  (byte_tlast),
        .m_axis_tready (byte_tready)
    );

    // start_q marks the first bit of every loaded byte, s7_q the first bit of 7-bit stuffing bytes.
    logic [RES_W-1:0]      res_q, res_d, start_q, start_d, s7_q, s7_d;
    logic [CNT_W-1:0]      res_cnt_q, res_cnt_d, len_q, len_d, ucnt_q, ucnt_d;
    logic                  prev_ff_q, prev_ff_d, last_seen_q, last_seen_d, align_ph_q, align_ph_d;
    hdr_state_e            state_q, state_d;
    logic                  rsp_valid_q, rsp_valid_d, rsp_last_q, rsp_last_d, req_ready_q, req_ready_d;
    logic [HDR_DATA_W-1:0] rsp_data_q, rsp_data_d, field_bits;
    logic [CNT_W-1:0]      consume, cnt_after, ones, nxt_dist, len_sat;
    logic                  run, nxt_found, seven;
    logic [7:0]            ins_byte;
`ifdef HDR_STUFF_CHK_EN
    logic                  stuff_err_q, stuff_err_d;
    assign stuff_err_o = stuff_err_q;
`endif

    assign byte_tready = (res_cnt_q <= LOAD_MAX);
    assign req_ready_o = req_ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_last_o  = rsp_last_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ucnt_d      = ucnt_q;
        align_ph_d  = align_ph_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        prev_ff_d   = prev_ff_q;
        last_seen_d = last_seen_q;
        consume     = '0;
        len_sat     = (int'(req_bit_cnt_i) > HDR_DATA_W) ? HDR_W_C : CNT_W'(req_bit_cnt_i);
        field_bits  = res_q[RES_W-1 -: HDR_DATA_W] >> (HDR_W_C - len_q);

        ones = '0;
        run  = 1'b1;
        for (int i = 0; i < RES_W; i++) begin
            if (run && i < int'(res_cnt_q) && res_q[RES_W-1-i]) ones = ones + CNT_W'(1);
            else run = 1'b0;
        end
        nxt_dist  = '0;
        nxt_found = 1'b0;
        for (int i = 1; i < RES_W; i++) begin
            if (!nxt_found && i < int'(res_cnt_q) && start_q[RES_W-1-i]) begin
                nxt_found = 1'b1;
                nxt_dist  = CNT_W'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    len_d      = len_sat;
                    ucnt_d     = '0;
                    align_ph_d = 1'b0;
                    if (req_mode_i != MODE_FIELD && req_mode_i != MODE_UNARY) state_d = ALIGN;
                    else if (len_sat == '0) begin
                        state_d    = RESP;
                        rsp_data_d = '0;
                    end else state_d = (req_mode_i == MODE_FIELD) ? FIELD_W : UNARY_W;
                end
            end
            FIELD_W: begin
                if (res_cnt_q >= len_q) begin
                    consume    = len_q;
                    rsp_data_d = field_bits;
                    state_d    = RESP;
                end
            end
            UNARY_W: begin
                if (ones >= len_q - ucnt_q) begin
                    consume    = len_q - ucnt_q;
                    rsp_data_d = HDR_DATA_W'(len_q);
                    state_d    = RESP;
                end else if (ones < res_cnt_q) begin
                    consume    = ones + CNT_W'(1);
                    rsp_data_d = HDR_DATA_W'(ucnt_q + ones);
                    state_d    = RESP;
                end else begin
                    consume = ones;
                    ucnt_d  = ucnt_q + ones;
                end
            end
            ALIGN: begin
                rsp_data_d = '0;
                if (!align_ph_q) begin
                    if (res_cnt_q != '0 && !start_q[RES_W-1]) consume = nxt_found ? nxt_dist : res_cnt_q;
                    align_ph_d = 1'b1;
                end else if (res_cnt_q != '0) begin
                    if (s7_q[RES_W-1]) consume = CNT_W'(7);
                    state_d = RESP;
                end else if (!prev_ff_q) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d    = IDLE;
                    rsp_data_d = '0;
                    rsp_last_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Consume shifts the reservoir up; a same-cycle load lands just below the survivors.
        cnt_after = res_cnt_q - consume;
        res_d     = res_q << consume;
        start_d   = start_q << consume;
        s7_d      = s7_q << consume;
        res_cnt_d = cnt_after;
        seven     = prev_ff_q;
        ins_byte  = seven ? {byte_tdata[6:0], 1'b0} : byte_tdata;
`ifdef HDR_STUFF_CHK_EN
        stuff_err_d = stuff_err_q;
`endif
        if (byte_tvalid && byte_tready) begin
            res_d       = res_d | ({ins_byte, {(RES_W-8){1'b0}}} >> cnt_after);
            start_d     = start_d | (TOP_BIT >> cnt_after);
            s7_d        = s7_d | (seven ? (TOP_BIT >> cnt_after) : '0);
            res_cnt_d   = cnt_after + (seven ? CNT_W'(7) : CNT_W'(8));
            prev_ff_d   = (byte_tdata == STUFF_BYTE);
            last_seen_d = byte_tlast;
`ifdef HDR_STUFF_CHK_EN
            stuff_err_d = stuff_err_q | (seven && byte_tdata[7]);
`endif
        end

        rsp_valid_d = (state_d == RESP);
        req_ready_d = (state_d == IDLE);
        if (state_d == RESP && state_q != RESP) rsp_last_d = last_seen_d && (res_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            res_q       <= '0;
            start_q     <= '0;
            s7_q        <= '0;
            res_cnt_q   <= '0;
            len_q       <= '0;
            ucnt_q      <= '0;
            align_ph_q  <= 1'b0;
            prev_ff_q   <= 1'b0;
            last_seen_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            start_q     <= start_d;
            s7_q        <= s7_d;
            res_cnt_q   <= res_cnt_d;
            len_q       <= len_d;
            ucnt_q      <= ucnt_d;
            align_ph_q  <= align_ph_d;
            prev_ff_q   <= prev_ff_d;
            last_seen_q <= last_seen_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef HDR_STUFF_CHK_EN
    always_ff @(posedge clk) begin
        if (rst) stuff_err_q <= 1'b0;
        else     stuff_err_q <= stuff_err_d;
    end
`endif

endmodule

// File: tb/tb_bit_disassembler.sv
// tb/tb_bit_disassembler.sv - directed self-checking bench for bit_disassembler.
module tb_bit_disassembler;

    logic        clk;
    logic        rst;
    logic        s_valid, s_last, s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        req_valid, req_ready;
    logic [1:0]  req_mode;
    logic [5:0]  req_bit_cnt;
    logic        rsp_valid, rsp_last, rsp_ready;
    logic [31:0] rsp_data;
`ifdef HDR_STUFF_CHK_EN
    logic        stuff_err;
`endif

    int checks = 0;
    int errors = 0;

    bit_disassembler dut (
        .clk                   (clk),
        .rst                   (rst),
        .s_axis_hdr_rx_valid_i (s_valid),
        .s_axis_hdr_rx_last_i  (s_last),
        .s_axis_hdr_rx_data_i  (s_data),
        .s_axis_hdr_rx_keep_i  (s_keep),
        .s_axis_hdr_rx_ready_o (s_ready),
        .req_valid_i           (req_valid),
        .req_mode_i            (req_mode),
        .req_bit_cnt_i         (req_bit_cnt),
        .req_ready_o           (req_ready),
        .rsp_valid_o           (rsp_valid),
        .rsp_data_o            (rsp_data),
        .rsp_last_o            (rsp_last),
`ifdef HDR_STUFF_CHK_EN
        .stuff_err_o           (stuff_err),
`endif
        .rsp_ready_i           (rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send_word(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        n = 0;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) check_eq({tag, " s_ready timeout"}, 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic issue_req(input string tag, input logic [1:0] mode, input logic [5:0] cnt, output int lat);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) check_eq({tag, " req_ready timeout"}, 32'(req_ready), 32'd1);
        req_valid   = 1'b1;
        req_mode    = mode;
        req_bit_cnt = cnt;
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) check_eq({tag, " rsp_valid timeout"}, 32'(rsp_valid), 32'd1);
    endtask

    task automatic do_req(input string tag, input logic [1:0] mode, input logic [5:0] cnt,
                          input logic [31:0] exp, input int exp_last, input int exp_lat, input int hold);
        int lat;
        issue_req(tag, mode, cnt, lat);
        if (exp_lat >= 0) check_eq({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check_eq(tag, rsp_data, exp);
        if (exp_last >= 0) check_eq({tag, " last"}, 32'(rsp_last), 32'(exp_last));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, " held data"}, rsp_data, exp);
        end
        if (hold > 0) check_eq({tag, " held valid"}, 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_keep = '0;
        req_valid = 1'b0; req_mode = '0; req_bit_cnt = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset s_ready", 32'(s_ready), 32'd0);
        check_eq("reset req_ready", 32'(req_ready), 32'd0);
        check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("reset rsp_data", rsp_data, 32'd0);
        check_eq("reset rsp_last", 32'(rsp_last), 32'd0);
`ifdef HDR_STUFF_CHK_EN
        check_eq("reset stuff_err", 32'(stuff_err), 32'd0);
`endif
        rst = 1'b0;

        // plain fields across a byte boundary
        send_word("t1 word", 32'h0000_3CA5, 4'b0011, 1'b1);
        do_req("t1 field4", 2'b00, 6'd4, 32'hA, 0, -1, 0);
        do_req("t1 field8", 2'b00, 6'd8, 32'h53, 0, 1, 0);
        do_req("t1 field4b", 2'b00, 6'd4, 32'hC, 1, -1, 0);

        // 0xFF followed by a 7-bit byte
        apply_reset();
        send_word("t2 word", 32'h0000_7FFF, 4'b0011, 1'b1);
        do_req("t2 field8", 2'b00, 6'd8, 32'hFF, -1, -1, 0);
        do_req("t2 field7", 2'b00, 6'd7, 32'h7F, 1, -1, 0);
`ifdef HDR_STUFF_CHK_EN
        check_eq("t2 stuff_err clean", 32'(stuff_err), 32'd0);
        apply_reset();
        send_word("t2 bad word", 32'h0000_FFFF, 4'b0011, 1'b1);
        repeat (6) @(negedge clk);
        check_eq("t2 stuff_err set", 32'(stuff_err), 32'd1);
`endif

        // unary with terminator, then the remaining bits
        apply_reset();
        send_word("t3 word", 32'h0000_00E8, 4'b0001, 1'b1);
        do_req("t3 unary", 2'b01, 6'd10, 32'd3, 0, -1, 0);
        do_req("t3 field4", 2'b00, 6'd4, 32'h8, 1, -1, 0);

        // unary run spanning a stuffed byte
        apply_reset();
        send_word("t4 word", 32'h00C0_7FFF, 4'b0111, 1'b1);
        do_req("t4 unary", 2'b01, 6'd31, 32'd17, 0, -1, 0);
        do_req("t4 field5", 2'b00, 6'd5, 32'h0, 1, -1, 0);

        // align drops the partial 0xFF and its stuffing byte
        apply_reset();
        send_word("t5 word0", 32'h0000_00FF, 4'b1111 & 4'b0001, 1'b0);
        send_word("t5 word1", 32'h0000_5A00, 4'b0011, 1'b1);
        do_req("t5 field3", 2'b00, 6'd3, 32'h7, -1, -1, 0);
        do_req("t5 align", 2'b10, 6'd0, 32'h0, -1, -1, 0);
        do_req("t5 field8", 2'b00, 6'd8, 32'h5A, 1, -1, 0);

        // saturation, zero length, held response
        apply_reset();
        send_word("t6 word0", 32'h7856_3412, 4'b1111, 1'b0);
        send_word("t6 word1", 32'h0000_009A, 4'b0001, 1'b1);
        do_req("t6 field40", 2'b00, 6'd40, 32'h1234_5678, 0, -1, 0);
        do_req("t6 field0", 2'b00, 6'd0, 32'h0, 0, 0, 0);
        do_req("t6 field8", 2'b00, 6'd8, 32'h9A, 1, -1, 5);

        // reset with a response pending drops everything
        apply_reset();
        send_word("t7 word0", 32'h0000_00C3, 4'b0001, 1'b0);
        do_req("t7 field4", 2'b00, 6'd4, 32'hC, 0, -1, 0);
        issue_req("t7 pending", 2'b00, 6'd4, lat);
        check_eq("t7 pending data", rsp_data, 32'h3);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t7 rst rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("t7 rst rsp_data", rsp_data, 32'd0);
        check_eq("t7 rst req_ready", 32'(req_ready), 32'd0);
        check_eq("t7 rst s_ready", 32'(s_ready), 32'd0);
        rst = 1'b0;
        send_word("t7 word1", 32'h0000_0096, 4'b0001, 1'b1);
        do_req("t7 field8", 2'b00, 6'd8, 32'h96, 1, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
